// File: rtl/hk_spi_responder.sv
// rtl/hk_spi_responder.sv - housekeeping SPI responder with register port and flash pass-thru
//
// Oversamples the host SPI pins on the core clock. The first byte is a command and the
// second is an address. Data bytes then stream to or from a byte-wide register port.
// A dedicated command instead bridges the host to the management flash and holds the
// CPU in reset while the bridge is open.
//
// Ports:
//   clock, resetb              core clock, asynchronous active-low reset
//   spi_sck/csb/sdi            host SPI inputs (asynchronous to clock)
//   spi_sdo, spi_sdo_oe        host SPI data out (MSB first) and its output enable
//   reg_addr/wdata/we/re       register port; reg_rdata is sampled the cycle after reg_re
//   reg_rdata                  register read data
//   flash_csb/sck/io0          flash-side SPI, driven only in pass-thru
//   flash_io1                  flash data out, returned to the host in pass-thru
//   pass_thru_active           high while the flash bridge is open
//   cpu_reset                  holds the management CPU in reset during pass-thru

module hk_spi_responder #(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [7:0] PASSTHRU_CMD = 8'hC4
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       spi_sck,
  input  logic       spi_csb,
  input  logic       spi_sdi,
  output logic       spi_sdo,
  output logic       spi_sdo_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       flash_csb,
  output logic       flash_sck,
  output logic       flash_io0,
  input  logic       flash_io1,
  output logic       pass_thru_active,
  output logic       cpu_reset
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE, PASSTHRU} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, csb_sync_q, sdi_sync_q;
  logic       sck_prev_q;
  logic [2:0] bitcnt_q;
  logic [7:0] rx_q;
  logic [1:0] mode_q;        // bit0 = read, bit1 = write
  logic [2:0] count_q;       // byte count from the command, 0 = stream
  logic [2:0] bytes_q;       // data bytes completed so far
  logic       adv_q;         // address advance pending (one cycle after a data byte)
  logic       rd_pend_q;     // reg_rdata is valid this cycle
  logic [7:0] sdo_shift_q;
  logic       sdo_q, oe_q;
  logic [7:0] reg_addr_q, reg_wdata_q;
  logic       reg_we_q, reg_re_q;
  logic       pt_q, arm_q, flash_csb_q, flash_sck_q, flash_io0_q, cpu_reset_q;

  logic       sck_s, csb_s, sdi_s, sck_rise, shifting, byte_done, last_byte, pt_cond;
  logic [7:0] rx_byte;

  assign sck_s     = sck_sync_q[SYNC_STAGES-1];
  assign csb_s     = csb_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sck_rise  = sck_s & ~sck_prev_q;
  assign shifting  = (state_q == CMD) || (state_q == ADDR) || (state_q == DATA);
  assign byte_done = shifting && sck_rise && (bitcnt_q == 3'd7);
  assign rx_byte   = {rx_q[6:0], sdi_s};
  assign last_byte = (count_q != 3'd0) && ((bytes_q + 3'd1) == count_q);
  assign pt_cond   = (state_q == PASSTHRU) && !csb_s;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!csb_s) state_d = CMD;
      CMD: begin
        if (byte_done) begin
          if (rx_byte == PASSTHRU_CMD)                           state_d = PASSTHRU;
          else if (rx_byte[7:6] != 2'b00 && rx_byte[2:0] == 3'b000) state_d = ADDR;
          else                                                   state_d = IGNORE;
        end
      end
      ADDR: if (byte_done) state_d = DATA;
      DATA: if (byte_done && last_byte) state_d = IGNORE;
      default: state_d = state_q;
    endcase
    // Deselect wins over everything, including a byte finishing in the same cycle.
    if (csb_s) state_d = IDLE;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      sck_sync_q  <= '0;
      csb_sync_q  <= {SYNC_STAGES{1'b1}};
      sdi_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      bitcnt_q    <= 3'd0;
      rx_q        <= 8'd0;
      mode_q      <= 2'd0;
      count_q     <= 3'd0;
      bytes_q     <= 3'd0;
      adv_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      sdo_shift_q <= 8'd0;
      sdo_q       <= 1'b0;
      oe_q        <= 1'b0;
      reg_addr_q  <= 8'd0;
      reg_wdata_q <= 8'd0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      pt_q        <= 1'b0;
      arm_q       <= 1'b0;
      flash_csb_q <= 1'b1;
      flash_sck_q <= 1'b0;
      flash_io0_q <= 1'b0;
      cpu_reset_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csb_sync_q <= {csb_sync_q[SYNC_STAGES-2:0], spi_csb};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sck_prev_q <= sck_s;

      reg_we_q  <= 1'b0;
      reg_re_q  <= 1'b0;
      adv_q     <= 1'b0;
      rd_pend_q <= reg_re_q;

      if (state_q == IDLE) begin
        bitcnt_q <= 3'd0;
        rx_q     <= 8'd0;
        bytes_q  <= 3'd0;
        sdo_q    <= 1'b0;
      end else if (shifting && sck_rise) begin
        rx_q     <= rx_byte;
        bitcnt_q <= bitcnt_q + 3'd1;
      end

      if (state_q == CMD && byte_done) begin
        mode_q  <= rx_byte[7:6];
        count_q <= rx_byte[5:3];
      end

      if (state_q == ADDR && byte_done && !csb_s) begin
        reg_addr_q <= rx_byte;
        reg_re_q   <= mode_q[0];
      end

      // Write strobe lands one cycle after the byte; the address advance and the
      // read of the next address follow a cycle later, so we and re never overlap.
      if (state_q == DATA && byte_done && !csb_s) begin
        bytes_q <= bytes_q + 3'd1;
        if (mode_q[1]) begin
          reg_we_q    <= 1'b1;
          reg_wdata_q <= rx_byte;
        end
        adv_q <= !last_byte;
      end

      if (adv_q && state_q == DATA && !csb_s) begin
        reg_addr_q <= reg_addr_q + 8'd1;
        reg_re_q   <= mode_q[0];
      end

      if (state_q == DATA && sck_rise) begin
        sdo_q       <= sdo_shift_q[6];
        sdo_shift_q <= {sdo_shift_q[6:0], 1'b0};
      end
      if (rd_pend_q) begin
        sdo_shift_q <= reg_rdata;
        sdo_q       <= reg_rdata[7];
      end

      oe_q <= !csb_s && ((state_q == PASSTHRU) ||
                         (state_q == DATA && mode_q[0] && (oe_q || rd_pend_q)));

      // The bridge opens while SCK is still high from the command's last bit; the
      // flash clock is held low until the host's SCK has gone low once, so the
      // flash never sees that leftover edge as a clock.
      pt_q        <= pt_cond;
      arm_q       <= pt_cond && (arm_q || !sck_s);
      flash_csb_q <= !pt_cond;
      flash_sck_q <= pt_cond && arm_q && sck_s;
      flash_io0_q <= pt_cond && arm_q && sdi_s;
      cpu_reset_q <= !flash_csb_q;
    end
  end

  assign spi_sdo          = pt_q ? flash_io1 : sdo_q;
  assign spi_sdo_oe       = oe_q;
  assign reg_addr         = reg_addr_q;
  assign reg_wdata        = reg_wdata_q;
  assign reg_we           = reg_we_q;
  assign reg_re           = reg_re_q;
  assign flash_csb        = flash_csb_q;
  assign flash_sck        = flash_sck_q;
  assign flash_io0        = flash_io0_q;
  assign pass_thru_active = pt_q;
  assign cpu_reset        = cpu_reset_q;

endmodule

// File: tb/tb_hk_spi_responder.sv
// tb/tb_hk_spi_responder.sv - self-checking bench for hk_spi_responder
module tb_hk_spi_responder;

  localparam int HP = 100;  // SCK half period, 10 core clocks

  logic clock = 1'b0;
  logic resetb, spi_sck, spi_csb, spi_sdi;
  logic spi_sdo, spi_sdo_oe, reg_we, reg_re;
  logic [7:0] reg_addr, reg_wdata, reg_rdata;
  logic flash_csb, flash_sck, flash_io0;
  logic flash_io1 = 1'b0;
  logic pass_thru_active, cpu_reset;

  always #5 clock = ~clock;

  hk_spi_responder dut (
    .clock(clock), .resetb(resetb),
    .spi_sck(spi_sck), .spi_csb(spi_csb), .spi_sdi(spi_sdi),
    .spi_sdo(spi_sdo), .spi_sdo_oe(spi_sdo_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata),
    .flash_csb(flash_csb), .flash_sck(flash_sck), .flash_io0(flash_io0), .flash_io1(flash_io1),
    .pass_thru_active(pass_thru_active), .cpu_reset(cpu_reset)
  );

  // Register file reference model, owned by the main sequence.
  logic [7:0] regs [256];
  assign reg_rdata = regs[reg_addr];

  // Port activity log.
  logic [15:0] wlog [64];
  int wcnt = 0, re_cnt = 0, re3_cnt = 0, both_cnt = 0;
  always @(posedge clock) begin
    if (reg_we && wcnt < 64) begin
      wlog[wcnt] <= {reg_addr, reg_wdata};
      wcnt <= wcnt + 1;
    end
    if (reg_re) begin
      re_cnt <= re_cnt + 1;
      if (reg_addr == 8'h03) re3_cnt <= re3_cnt + 1;
    end
    if (reg_we && reg_re) both_cnt <= both_cnt + 1;
  end

  // SPI flash model: 8-bit command, 24-bit address, data out on falling clock.
  logic [7:0]  fmem [8];
  int          fbits = 0;
  logic [31:0] fhdr = 32'd0;
  always @(posedge flash_sck or posedge flash_csb) begin
    if (flash_csb) fbits <= 0;
    else begin
      if (fbits < 32) fhdr <= {fhdr[30:0], flash_io0};
      fbits <= fbits + 1;
    end
  end
  always @(negedge flash_sck) begin
    if (!flash_csb && fbits >= 32) begin
      logic [23:0] fa;
      logic [7:0]  fb;
      fa = fhdr[23:0] + 24'((fbits - 32) / 8);
      fb = fmem[fa[2:0]];
      flash_io1 = fb[7 - ((fbits - 32) % 8)];
    end
  end

  int errors = 0, checks = 0;
  logic oe_or, cpu_and;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_sdi = tx[i];
      #(HP);
      spi_sck = 1'b1;
      rx[i]   = spi_sdo;
      oe_or   = oe_or | spi_sdo_oe;
      cpu_and = cpu_and & cpu_reset;
      #(HP);
      spi_sck = 1'b0;
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  task automatic cs_start();
    spi_csb = 1'b0;
    #(HP);
  endtask

  task automatic cs_end();
    #(HP);
    spi_csb = 1'b1;
    #(2 * HP);
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rx, a, tx [3], snap [3];
    logic [7:0] fexp [8];
    int n, w0, r0, r3;

    fexp = '{8'h93, 8'h00, 8'h00, 8'h00, 8'h93, 8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) fmem[i] = fexp[i];
    for (int i = 0; i < 256; i++) regs[i] = 8'($urandom);
    regs[8'h03] = 8'h10;
    oe_or = 1'b0; cpu_and = 1'b1;

    resetb = 1'b0; spi_csb = 1'b1; spi_sck = 1'b0; spi_sdi = 1'b0;
    repeat (5) @(posedge clock);
    #2;
    chk("rst_sdo", spi_sdo, 0);
    chk("rst_oe", spi_sdo_oe, 0);
    chk("rst_reg", {reg_addr, reg_wdata, reg_we, reg_re}, 0);
    chk("rst_flash", {flash_csb, flash_sck, flash_io0}, 3'b100);
    chk("rst_pt_cpu", {pass_thru_active, cpu_reset}, 0);
    resetb = 1'b1;
    #(2 * HP);

    // Single-byte read at address 3
    r3 = re3_cnt;
    cs_start();
    spi_byte(8'h40, rx); spi_byte(8'h03, rx); spi_byte(8'h00, rx);
    cs_end();
    chk("t1_rdata", rx, 8'h10);
    chk("t1_re_at3", re3_cnt - r3, 1);

    // Write stream across the address wrap
    w0 = wcnt;
    cs_start();
    spi_byte(8'h80, rx); spi_byte(8'hFE, rx);
    spi_byte(8'hAA, rx); spi_byte(8'h55, rx); spi_byte(8'h11, rx);
    cs_end();
    chk("t2_wcnt", wcnt - w0, 3);
    chk("t2_w0", wlog[w0],     16'hFEAA);
    chk("t2_w1", wlog[w0 + 1], 16'hFF55);
    chk("t2_w2", wlog[w0 + 2], 16'h0011);
    regs[8'hFE] = 8'hAA; regs[8'hFF] = 8'h55; regs[8'h00] = 8'h11;

    // Counted read of 1 byte; the second byte must not be driven
    r0 = re_cnt;
    cs_start();
    spi_byte(8'h48, rx); spi_byte(8'h03, rx);
    spi_byte(8'h00, rx);
    chk("t3_rdata", rx, 8'h10);
    oe_or = 1'b0;
    spi_byte(8'h00, rx);
    chk("t3_oe_byte2", oe_or, 0);
    cs_end();
    chk("t3_re_cnt", re_cnt - r0, 1);

    // Flash pass-thru
    cs_start();
    spi_byte(8'hC4, rx);
    cpu_and = 1'b1;
    spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx);
    chk("t4_pt_active", pass_thru_active, 1);
    for (int k = 0; k < 8; k++) begin
      spi_byte(8'h00, rx);
      chk("t4_flash_data", rx, fexp[k]);
    end
    chk("t4_cpu_reset_held", cpu_and, 1);
    #(HP);
    @(posedge clock); #2;
    spi_csb = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      n++;
      if (flash_csb) break;
    end
    chk("t4_flash_csb_rise", flash_csb, 1);
    chk("t4_csb_latency_ok", n <= 3, 1);
    chk("t4_cpu_lag", cpu_reset, 1);
    @(posedge clock); #1;
    chk("t4_cpu_released", cpu_reset, 0);
    chk("t4_pt_clear", {pass_thru_active, spi_sdo_oe, flash_sck}, 0);
    #(2 * HP);

    // Partial write byte is discarded
    w0 = wcnt;
    cs_start();
    spi_byte(8'h80, rx); spi_byte(8'h10, rx);
    spi_bits(8'hF0, 4, rx);
    cs_end();
    chk("t5_no_we", wcnt - w0, 0);
    cs_start();
    spi_byte(8'h40, rx); spi_byte(8'h03, rx); spi_byte(8'h00, rx);
    cs_end();
    chk("t5_rdata", rx, regs[8'h03]);

    // Random counted read
    a = 8'($urandom);
    n = $urandom_range(1, 7);
    r0 = re_cnt;
    cs_start();
    spi_byte(8'h40 | 8'(n << 3), rx); spi_byte(a, rx);
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, rx);
      chk("rnd_rd", rx, regs[8'(a + k)]);
    end
    cs_end();
    chk("rnd_re_cnt", re_cnt - r0, n);

    // Random read+write stream: each byte returns the old contents
    a = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      tx[k]   = 8'($urandom);
      snap[k] = regs[8'(a + k)];
    end
    w0 = wcnt;
    cs_start();
    spi_byte(8'hC0, rx); spi_byte(a, rx);
    for (int k = 0; k < 3; k++) begin
      spi_byte(tx[k], rx);
      chk("rw_rd", rx, snap[k]);
    end
    cs_end();
    chk("rw_wcnt", wcnt - w0, 3);
    for (int k = 0; k < 3; k++) begin
      chk("rw_we", wlog[w0 + k], {8'(a + k), tx[k]});
      regs[8'(a + k)] = tx[k];
    end
    cs_start();
    spi_byte(8'h58, rx); spi_byte(a, rx);
    for (int k = 0; k < 3; k++) begin
      spi_byte(8'h00, rx);
      chk("rw_readback", rx, tx[k]);
    end
    cs_end();

    // Reset asserted mid pass-thru
    cs_start();
    spi_byte(8'hC4, rx);
    repeat (6) @(posedge clock);
    #1;
    chk("t6_pt_before", {pass_thru_active, cpu_reset, flash_csb}, 3'b110);
    resetb = 1'b0;
    #1;
    chk("t6_rst_flash_csb", flash_csb, 1);
    chk("t6_rst_cpu", cpu_reset, 0);
    chk("t6_rst_oe", spi_sdo_oe, 0);
    spi_csb = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    resetb = 1'b1;
    #(2 * HP);
    chk("t6_idle_pt", {pass_thru_active, flash_csb}, 2'b01);
    cs_start();
    spi_byte(8'h40, rx); spi_byte(8'h03, rx); spi_byte(8'h00, rx);
    cs_end();
    chk("t6_after_rdata", rx, regs[8'h03]);

    chk("we_re_overlap", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
